// File: rtl/motor_pwm_ramp.sv
// Single-channel H-bridge motor driver: ramped duty toward a commanded target, safe reversal
// (decelerate, coast, re-accelerate) and glitch-free PWM. Define CMD_TIMEOUT_EN for the watchdog.
module motor_pwm_ramp #(
  parameter int unsigned STEP       = 4,
  parameter int unsigned DEAD_TICKS = 8,
  parameter int unsigned PWM_DIV    = 8
`ifdef CMD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_TICKS = 1525
`endif
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_speed,
  input  logic       cmd_dir,
  output logic       pwm_en,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       at_speed,
  output logic       timeout
);

  localparam logic [7:0]        STEP_W    = 8'(STEP);
  localparam int unsigned       DEAD_W    = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam int unsigned       DIV_W     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_TICKS);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PWM_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [7:0]        PWM_TOP   = 8'd254;

  typedef enum logic [1:0] {StIdle, StRun, StDecel, StDead} state_e;

  state_e            r_state;
  logic [7:0]        r_cur;
  logic [7:0]        r_target;
  logic              r_dir;
  logic [7:0]        r_pend_speed;
  logic              r_pend_dir;
  logic [DEAD_W-1:0] r_dead_cnt;

  logic              r_sync1, r_sync2, r_sync3, r_tick;
  logic [DIV_W-1:0]  r_div;
  logic [7:0]        r_pwm_cnt;
  logic [7:0]        r_duty_lat;

  logic              w_accept;
  logic              w_drive;
  logic              w_wd_fire;
  logic [7:0]        w_diff;
  logic [7:0]        w_cur_ramp;

  // slow_clk is asynchronous: two flops for metastability, a third for rising-edge detect
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= slow_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;
    end
  end

  // Step toward target, clamped so the last step lands exactly on it
  always_comb begin
    w_diff     = 8'd0;
    w_cur_ramp = r_cur;
    if (r_cur < r_target) begin
      w_diff     = r_target - r_cur;
      w_cur_ramp = r_cur + ((w_diff < STEP_W) ? w_diff : STEP_W);
    end else if (r_cur > r_target) begin
      w_diff     = r_cur - r_target;
      w_cur_ramp = r_cur - ((w_diff < STEP_W) ? w_diff : STEP_W);
    end
  end

  assign cmd_ready = (r_state == StIdle) || (r_state == StRun);
  assign w_accept  = cmd_valid & cmd_ready;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned     WD_W     = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_TICKS);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (w_accept) begin
      r_wd_cnt <= '0;
    end else if (r_tick && (r_wd_cnt != WD_LIMIT)) begin
      r_wd_cnt <= r_wd_cnt + WD_ONE;
    end
  end

  // Fire once; the flag keeps RUN from re-arming so the ramp-down can reach IDLE
  assign w_wd_fire = (r_wd_cnt == WD_LIMIT) && !r_timeout;
  assign timeout   = r_timeout;
`else
  assign w_wd_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cur        <= 8'd0;
      r_target     <= 8'd0;
      r_dir        <= 1'b1;
      r_pend_speed <= 8'd0;
      r_pend_dir   <= 1'b1;
      r_dead_cnt   <= '0;
`ifdef CMD_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      // A tick in the accept cycle still ramps toward the old target
      if (r_tick) begin
        r_cur <= w_cur_ramp;
      end
`ifdef CMD_TIMEOUT_EN
      if (w_accept) begin
        r_timeout <= 1'b0;
      end
`endif
      unique case (r_state)
        StIdle: begin
          if (w_accept && (cmd_speed != 8'd0)) begin
            r_state  <= StRun;
            r_dir    <= cmd_dir;
            r_target <= cmd_speed;
          end
        end
        StRun: begin
          if (w_accept) begin
            if ((cmd_dir != r_dir) && (r_cur != 8'd0)) begin
              r_state      <= StDecel;
              r_pend_speed <= cmd_speed;
              r_pend_dir   <= cmd_dir;
              r_target     <= 8'd0;
            end else begin
              r_target <= cmd_speed;
              r_dir    <= cmd_dir;
            end
          end else if (w_wd_fire) begin
            r_target <= 8'd0;
`ifdef CMD_TIMEOUT_EN
            r_timeout <= 1'b1;
`endif
          end else if ((r_target == 8'd0) && (r_cur == 8'd0)) begin
            r_state <= StIdle;
          end
        end
        StDecel: begin
          if (r_cur == 8'd0) begin
            r_state    <= StDead;
            r_dead_cnt <= DEAD_INIT;
          end
        end
        StDead: begin
          if (r_tick) begin
            if (r_dead_cnt <= DEAD_ONE) begin
              r_state  <= StRun;
              r_dir    <= r_pend_dir;
              r_target <= r_pend_speed;
            end else begin
              r_dead_cnt <= r_dead_cnt - DEAD_ONE;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Duty is latched only at the counter wrap so a period is never cut short or stretched
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_pwm_cnt  <= 8'd0;
      r_duty_lat <= 8'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      if (r_pwm_cnt == PWM_TOP) begin
        r_pwm_cnt  <= 8'd0;
        r_duty_lat <= r_cur;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  assign w_drive  = (r_state == StRun) || (r_state == StDecel);
  assign pwm_en   = (r_pwm_cnt < r_duty_lat);
  assign in1      = w_drive & r_dir;
  assign in2      = w_drive & ~r_dir;
  assign busy     = (r_state != StIdle);
  assign at_speed = (r_state == StRun) && (r_cur == r_target);

endmodule
